aria_sl_seq: RTL and testbench



---
 rtl/aria_sl_seq.sv | 105 ++++++++++
 tb/tb_aria_sl_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aria_sl_seq.sv
// Word-serial ARIA substitution-layer sequencer: latches state ^ round key, streams four
// 32-bit words (MSW first) through an external aria_lt S-box word and reassembles the result.
module aria_sl_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sl_clr,
  input  logic         sl_in_valid,
  output logic         sl_in_ready,
  input  logic [127:0] sl_din,
  input  logic [127:0] sl_rk,
  input  logic         sl_conf_inv,
  output logic         sl_out_valid,
  input  logic         sl_out_ready,
  output logic [127:0] sl_dout,
  output logic         sl_busy,
  output logic [31:0]  sl_lt_din,
  output logic         sl_lt_conf_inv,
  input  logic [31:0]  sl_lt_dout
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         conf_q, conf_d;
  logic [127:0] work_q, work_d;
  logic [127:0] dout_q, dout_d;
  logic [31:0]  work_word;

  always_comb begin
    work_word = 32'h0;
    unique case (cnt_q)
      2'd0: work_word = work_q[127:96];
      2'd1: work_word = work_q[95:64];
      2'd2: work_word = work_q[63:32];
      2'd3: work_word = work_q[31:0];
      default: work_word = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    conf_d  = conf_q;
    work_d  = work_q;
    dout_d  = dout_q;
    unique case (state_q)
      StIdle: begin
        if (sl_in_valid && !sl_clr) begin
          work_d  = sl_din ^ sl_rk;
          conf_d  = sl_conf_inv;
          cnt_d   = 2'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!sl_clr) begin
          unique case (cnt_q)
            2'd0: dout_d[127:96] = sl_lt_dout;
            2'd1: dout_d[95:64]  = sl_lt_dout;
            2'd2: dout_d[63:32]  = sl_lt_dout;
            2'd3: dout_d[31:0]   = sl_lt_dout;
            default: dout_d = dout_q;
          endcase
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = StDone;
        end
      end
      StDone: begin
        if (sl_out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Clear wins over every transition but leaves the result register alone.
    if (sl_clr) begin
      state_d = StIdle;
      cnt_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      conf_q  <= 1'b0;
      work_q  <= 128'h0;
      dout_q  <= 128'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      conf_q  <= conf_d;
      work_q  <= work_d;
      dout_q  <= dout_d;
    end
  end

  // rst_n gates ready so nothing is offered while reset is held.
  assign sl_in_ready    = rst_n && (state_q == StIdle);
  assign sl_out_valid   = (state_q == StDone);
  assign sl_busy        = (state_q != StIdle);
  assign sl_dout        = dout_q;
  assign sl_lt_din      = (state_q == StRun) ? work_word : 32'h0;
  assign sl_lt_conf_inv = conf_q;

endmodule

// File: tb/tb_aria_sl_seq.sv
// Bench for aria_sl_seq: behavioural aria_lt stand-in, vector table, scoreboard and
// hand-written backpressure / clear / reset sequences.
module tb_aria_sl_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sl_clr;
  logic         sl_in_valid;
  logic         sl_in_ready;
  logic [127:0] sl_din;
  logic [127:0] sl_rk;
  logic         sl_conf_inv;
  logic         sl_out_valid;
  logic         sl_out_ready;
  logic [127:0] sl_dout;
  logic         sl_busy;
  logic [31:0]  sl_lt_din;
  logic         sl_lt_conf_inv;
  logic [31:0]  sl_lt_dout;

  int checks = 0;
  int errors = 0;

  logic [127:0] sb[$];
  logic [127:0] cur_exp;
  logic [127:0] last_res;

  always #5 clk = ~clk;

  aria_sl_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sl_clr        (sl_clr),
    .sl_in_valid   (sl_in_valid),
    .sl_in_ready   (sl_in_ready),
    .sl_din        (sl_din),
    .sl_rk         (sl_rk),
    .sl_conf_inv   (sl_conf_inv),
    .sl_out_valid  (sl_out_valid),
    .sl_out_ready  (sl_out_ready),
    .sl_dout       (sl_dout),
    .sl_busy       (sl_busy),
    .sl_lt_din     (sl_lt_din),
    .sl_lt_conf_inv(sl_lt_conf_inv),
    .sl_lt_dout    (sl_lt_dout)
  );

  // Stand-in for aria_lt: matches the real S-box words at zero input, scrambles otherwise.
  function automatic logic [31:0] lt_model(input logic [31:0] w, input logic inv);
    logic [31:0] base;
    base = inv ? 32'h5230_63E2 : 32'h63E2_5230;
    return base ^ {w[23:0], w[31:24]} ^ ({w[15:0], w[31:16]} & w);
  endfunction

  function automatic logic [127:0] sl_model(input logic [127:0] din, input logic [127:0] rk,
                                            input logic inv);
    logic [127:0] x;
    logic [127:0] r;
    x = din ^ rk;
    r = '0;
    for (int i = 0; i < 4; i++) r[127-32*i -: 32] = lt_model(x[127-32*i -: 32], inv);
    return r;
  endfunction

  assign sl_lt_dout = lt_model(sl_lt_din, sl_lt_conf_inv);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Observe handshakes at the falling edge, then advance past the next rising edge.
  task automatic step();
    logic [127:0] e;
    @(negedge clk);
    if (sl_in_valid && sl_in_ready && !sl_clr) sb.push_back(cur_exp);
    if (sl_out_valid && sl_out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_output: got %h expected none", sl_dout);
      end else begin
        e = sb.pop_front();
        chk("sb_dout", sl_dout, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [127:0] din, input logic [127:0] rk, input logic inv,
                           input logic [127:0] exp, input bit hold);
    logic [127:0] x;
    int w;
    sl_din      = din;
    sl_rk       = rk;
    sl_conf_inv = inv;
    cur_exp     = exp;
    sl_in_valid = 1'b1;
    w = 0;
    while (!sl_in_ready && w < 20) begin
      step();
      w++;
    end
    if (w == 20) chk("accept_timeout", 128'(sl_in_ready), 128'(1));
    step();
    sl_in_valid = 1'b0;
    sl_din      = ~din;
    sl_rk       = 128'h0;
    sl_conf_inv = ~inv;
    x = din ^ rk;
    for (int k = 0; k < 4; k++) begin
      chk("lt_din_word", 128'(sl_lt_din), 128'(x[127-32*k -: 32]));
      chk("lt_conf_inv", 128'(sl_lt_conf_inv), 128'(inv));
      chk("out_valid_low_in_run", 128'(sl_out_valid), 128'(0));
      step();
    end
    chk("out_valid_at_e4", 128'(sl_out_valid), 128'(1));
    chk("dout_at_e4", sl_dout, exp);
    last_res = exp;
    if (!hold) begin
      step();
      chk("idle_after_done", 128'(sl_in_ready), 128'(1));
      chk("busy_after_done", 128'(sl_busy), 128'(0));
      chk("dout_held", sl_dout, exp);
    end
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] rk;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] a, b, c, d, kk, e_ab;
    rst_n        = 1'b0;
    sl_clr       = 1'b0;
    sl_in_valid  = 1'b0;
    sl_din       = '0;
    sl_rk        = '0;
    sl_conf_inv  = 1'b0;
    sl_out_ready = 1'b1;
    cur_exp      = '0;
    last_res     = '0;

    vecs[0] = '{128'h0, 128'h0, 1'b0, 128'h63E25230_63E25230_63E25230_63E25230};
    vecs[1] = '{128'h0, 128'h0, 1'b1, 128'h523063E2_523063E2_523063E2_523063E2};
    vecs[2] = '{128'h0123456789ABCDEFFEDCBA9876543210, 128'h0123456789ABCDEFFEDCBA9876543210,
                1'b0, 128'h63E25230_63E25230_63E25230_63E25230};
    a = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    vecs[3] = '{a, 128'h0, 1'b0, sl_model(a, 128'h0, 1'b0)};
    b  = {$urandom, $urandom, $urandom, $urandom};
    kk = {$urandom, $urandom, $urandom, $urandom};
    vecs[4] = '{b, kk, 1'b1, sl_model(b, kk, 1'b1)};

    #12;
    chk("ready_in_reset", 128'(sl_in_ready), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_ready", 128'(sl_in_ready), 128'(1));
    chk("reset_out_valid", 128'(sl_out_valid), 128'(0));
    chk("reset_busy", 128'(sl_busy), 128'(0));
    chk("reset_dout", sl_dout, 128'h0);
    chk("reset_lt_din", 128'(sl_lt_din), 128'(0));
    chk("reset_lt_conf", 128'(sl_lt_conf_inv), 128'(0));

    for (int i = 0; i < 5; i++) run_block(vecs[i].din, vecs[i].rk, vecs[i].inv, vecs[i].exp, 0);

    // Backpressure: result must sit still and no new block may slip in.
    c = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    d = 128'h11111111_22222222_33333333_44444444;
    sl_out_ready = 1'b0;
    run_block(c, 128'h0, 1'b0, sl_model(c, 128'h0, 1'b0), 1);
    sl_din      = d;
    sl_rk       = 128'h0;
    sl_conf_inv = 1'b1;
    cur_exp     = sl_model(d, 128'h0, 1'b1);
    sl_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_dout_stable", sl_dout, sl_model(c, 128'h0, 1'b0));
      chk("bp_in_ready_low", 128'(sl_in_ready), 128'(0));
      chk("bp_out_valid_held", 128'(sl_out_valid), 128'(1));
      step();
    end
    sl_in_valid  = 1'b0;
    sl_out_ready = 1'b1;
    step();
    chk("bp_release_idle", 128'(sl_busy), 128'(0));
    chk("bp_release_ready", 128'(sl_in_ready), 128'(1));
    run_block(d, 128'h0, 1'b1, sl_model(d, 128'h0, 1'b1), 0);

    // Clear at cnt=2 with a competing valid: words 0-1 of the aborted block remain in dout.
    a = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    b = 128'h13579BDF_2468ACE0_FDB97531_0ECA8642;
    sl_din      = a;
    sl_rk       = 128'h0;
    sl_conf_inv = 1'b0;
    cur_exp     = sl_model(a, 128'h0, 1'b0);
    sl_in_valid = 1'b1;
    step();
    sl_in_valid = 1'b0;
    step();
    step();
    chk("clr_lt_din_cnt2", 128'(sl_lt_din), 128'(a[63:32]));
    void'(sb.pop_back());
    sl_clr      = 1'b1;
    sl_in_valid = 1'b1;
    sl_din      = b;
    cur_exp     = sl_model(b, 128'h0, 1'b0);
    step();
    sl_clr      = 1'b0;
    sl_in_valid = 1'b0;
    e_ab = {sl_model(a, 128'h0, 1'b0) >> 64 << 64} | (last_res & 128'h0000000000000000_FFFFFFFFFFFFFFFF);
    chk("clr_busy", 128'(sl_busy), 128'(0));
    chk("clr_out_valid", 128'(sl_out_valid), 128'(0));
    chk("clr_lt_din", 128'(sl_lt_din), 128'(0));
    chk("clr_ready", 128'(sl_in_ready), 128'(1));
    chk("clr_dout_kept", sl_dout, e_ab);
    for (int i = 0; i < 6; i++) begin
      chk("clr_no_out_valid", 128'(sl_out_valid), 128'(0));
      step();
    end
    chk("clr_sb_empty", 128'(sb.size()), 128'(0));
    run_block(b, 128'h0, 1'b0, sl_model(b, 128'h0, 1'b0), 0);

    // Asynchronous reset in the middle of RUN.
    c = 128'hFFFFFFFF_00000000_12345678_9ABCDEF0;
    sl_din      = c;
    sl_rk       = 128'h0;
    sl_conf_inv = 1'b1;
    cur_exp     = sl_model(c, 128'h0, 1'b1);
    sl_in_valid = 1'b1;
    step();
    sl_in_valid = 1'b0;
    step();
    step();
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("rst_out_valid", 128'(sl_out_valid), 128'(0));
    chk("rst_busy", 128'(sl_busy), 128'(0));
    chk("rst_dout", sl_dout, 128'h0);
    chk("rst_ready_low", 128'(sl_in_ready), 128'(0));
    chk("rst_lt_din", 128'(sl_lt_din), 128'(0));
    chk("rst_lt_conf", 128'(sl_lt_conf_inv), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", 128'(sl_in_ready), 128'(1));
    @(posedge clk);
    #1;
    run_block(vecs[0].din, vecs[0].rk, vecs[0].inv, vecs[0].exp, 0);
    chk("final_sb_empty", 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
